regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two requesters: the in-order pipeline writeback (WB) and the multi-cycle multiply/divide unit (MDU).
- Buffers MDU results in a small FIFO until a write slot is free.
- Keeps a pending-destination scoreboard so the hazard unit can stall dependent reads.
- Sits between the WB stage / MDU and the register file's RegWrite/WriteAddr/WriteData inputs.

---
 rtl/regfile_wb_arbiter.sv | 91 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between WB and a buffered MDU result FIFO.
// Optional starvation guard enabled by REGFILE_WB_ARB_STARVE_EN.
module regfile_wb_arbiter #(
  parameter int BUF_DEPTH  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wb_valid,
  input  logic [4:0]                   wb_addr,
  input  logic [31:0]                  wb_data,
  output logic                         wb_hold,
  input  logic                         mdu_issue,
  input  logic [4:0]                   mdu_issue_addr,
  input  logic                         mdu_valid,
  input  logic [4:0]                   mdu_addr,
  input  logic [31:0]                  mdu_data,
  output logic                         mdu_ready,
  input  logic [4:0]                   chk_addr1,
  input  logic [4:0]                   chk_addr2,
  output logic                         chk_busy1,
  output logic                         chk_busy2,
  output logic                         rf_we,
  output logic [4:0]                   rf_waddr,
  output logic [31:0]                  rf_wdata,
  output logic [$clog2(BUF_DEPTH):0]   buf_count,
  output logic                         err_sticky
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  logic [4:0]    fa [BUF_DEPTH];
  logic [31:0]   fd [BUF_DEPTH];
  logic [AW-1:0] rp, wp;
  logic [CW-1:0] cnt;
  logic [31:0]   sb, sb_next;
  logic          wbreq, nonempty, starved, grant_buf, grant_wb, push, err_next;
  logic [4:0]    head_addr;
  assign head_addr = fa[rp];
  assign wbreq     = wb_valid && wb_addr != 5'd0;
  assign nonempty  = cnt != '0;
  assign mdu_ready = cnt < CW'(BUF_DEPTH);
  assign push      = mdu_valid && mdu_ready;
  assign grant_buf = nonempty && (!wbreq || starved);
  assign grant_wb  = wbreq && !grant_buf;
  assign wb_hold   = wbreq && grant_buf;
  assign rf_we     = grant_wb || grant_buf;
  assign rf_waddr  = grant_buf ? head_addr : grant_wb ? wb_addr : 5'd0;
  assign rf_wdata  = grant_buf ? fd[rp] : grant_wb ? wb_data : 32'd0;
  assign chk_busy1 = sb[chk_addr1];
  assign chk_busy2 = sb[chk_addr2];
  assign buf_count = cnt;
`ifdef REGFILE_WB_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;
  assign starved = starve_cnt == SW'(STARVE_MAX);
  always_ff @(posedge clk)
    if (reset || !nonempty || grant_buf) starve_cnt <= '0;
    else if (!starved) starve_cnt <= starve_cnt + 1'b1;
`else
  localparam int unused_starve_max = STARVE_MAX;
  assign starved = 1'b0;
`endif
  // issue sets after the grant clears so a same-cycle set on the same address wins
  always_comb begin
    sb_next = sb;
    if (grant_buf) sb_next[head_addr] = 1'b0;
    if (mdu_issue) sb_next[mdu_issue_addr] = 1'b1;
    sb_next[0] = 1'b0;
    err_next = (mdu_valid && !mdu_ready) || (mdu_issue && sb[mdu_issue_addr]) ||
               (mdu_valid && !sb[mdu_addr]) || (grant_wb && sb[wb_addr]);
  end
  always_ff @(posedge clk)
    if (push) begin
      fa[wp] <= mdu_addr;
      fd[wp] <= mdu_data;
    end
  always_ff @(posedge clk)
    if (reset) begin
      rp         <= '0;
      wp         <= '0;
      cnt        <= '0;
      sb         <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (grant_buf) rp <= rp + 1'b1;
      cnt        <= cnt + CW'(push) - CW'(grant_buf);
      sb         <= sb_next;
      err_sticky <= err_sticky || err_next;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized scoreboard bench for regfile_wb_arbiter against a queue-based model.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;
`ifdef REGFILE_WB_ARB_STARVE_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif
  logic clk = 1'b0, reset;
  logic wb_valid, wb_hold, mdu_issue, mdu_valid, mdu_ready, chk_busy1, chk_busy2, rf_we, err_sticky;
  logic [4:0] wb_addr, mdu_issue_addr, mdu_addr, chk_addr1, chk_addr2, rf_waddr;
  logic [31:0] wb_data, mdu_data, rf_wdata;
  logic [1:0] buf_count;

  regfile_wb_arbiter #(.BUF_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_hold(wb_hold), .mdu_issue(mdu_issue), .mdu_issue_addr(mdu_issue_addr),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .buf_count(buf_count),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic we; logic [4:0] waddr; logic [31:0] wdata;
    logic hold, ready, busy1, busy2; logic [1:0] count; logic err;
  } exp_t;

  exp_t exp_q[$];
  logic [36:0] mq[$];
  logic [4:0] iss_q[$];
  bit pend[32];
  int starve;
  bit merr, held;
  int total = 0, bad = 0, cyc = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", n, cyc, act, want);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  exp_t e;
  always @(negedge clk)
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rf_we", rf_we, e.we);
      chk("rf_waddr", rf_waddr, e.waddr);
      chk("rf_wdata", rf_wdata, e.wdata);
      chk("wb_hold", wb_hold, e.hold);
      chk("mdu_ready", mdu_ready, e.ready);
      chk("chk_busy1", chk_busy1, e.busy1);
      chk("chk_busy2", chk_busy2, e.busy2);
      chk("buf_count", buf_count, e.count);
      chk("err_sticky", err_sticky, e.err);
      cyc++;
    end

  task automatic model_clear();
    mq.delete();
    iss_q.delete();
    foreach (pend[i]) pend[i] = 0;
    starve = 0;
    merr = 0;
    held = 0;
  endtask

  // Predict this cycle's outputs from the model, then advance the model by one clock.
  task automatic step();
    bit wbreq, ne, stv, gb, gw, rdy;
    logic [4:0] ha;
    exp_t x;
    wbreq = wb_valid && wb_addr != 0;
    ne = mq.size() != 0;
    stv = SEN && starve == SMAX;
    gb = ne && (!wbreq || stv);
    gw = wbreq && !gb;
    rdy = mq.size() < DEPTH;
    ha = ne ? mq[0][36:32] : 5'd0;
    x.we = gb || gw;
    x.waddr = gb ? ha : gw ? wb_addr : 5'd0;
    x.wdata = gb ? mq[0][31:0] : gw ? wb_data : 32'd0;
    x.hold = wbreq && gb;
    x.ready = rdy;
    x.busy1 = pend[chk_addr1];
    x.busy2 = pend[chk_addr2];
    x.count = 2'(mq.size());
    x.err = merr;
    exp_q.push_back(x);
    held = x.hold;
    if (reset) model_clear();
    else begin
      if ((mdu_valid && !rdy) || (mdu_issue && pend[mdu_issue_addr]) ||
          (mdu_valid && !pend[mdu_addr]) || (gw && pend[wb_addr])) merr = 1;
      if (gb) begin
        pend[ha] = 0;
        void'(mq.pop_front());
      end
      if (mdu_issue) pend[mdu_issue_addr] = 1;
      pend[0] = 0;
      if (mdu_valid && rdy) mq.push_back({mdu_addr, mdu_data});
      if (!ne || gb) starve = 0;
      else if (starve < SMAX) starve++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    mdu_issue = 0; mdu_issue_addr = 0;
    mdu_valid = 0; mdu_addr = 0; mdu_data = 0;
  endtask

  task automatic rand_cycle();
    logic [4:0] a;
    if (!held) begin
      wb_valid = 1'($urandom_range(0, 1));
      wb_addr = 5'($urandom_range(0, 31));
      if (pend[wb_addr] && $urandom_range(0, 31) != 0) wb_addr = 0;
      wb_data = $urandom;
    end
    if (iss_q.size() != 0 && $urandom_range(0, 2) == 0 && (mq.size() < DEPTH || $urandom_range(0, 15) == 0)) begin
      mdu_valid = 1;
      mdu_addr = iss_q.pop_front();
    end else begin
      mdu_valid = 0;
      mdu_addr = 5'($urandom_range(0, 31));
    end
    mdu_data = $urandom;
    a = 5'($urandom_range(1, 31));
    mdu_issue = $urandom_range(0, 3) == 0 && !pend[a] && a != wb_addr && a != mdu_addr;
    mdu_issue_addr = a;
    if (mdu_issue) iss_q.push_back(a);
    chk_addr1 = 5'($urandom_range(0, 31));
    chk_addr2 = iss_q.size() != 0 ? iss_q[0] : 5'($urandom_range(0, 31));
    step();
  endtask

  initial begin
    idle();
    chk_addr1 = 0; chk_addr2 = 0;
    reset = 1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    // plain WB write
    wb_valid = 1; wb_addr = 8; wb_data = 32'h1234; chk_addr1 = 8;
    step();
    idle();
    // MDU issue, result, drain with WB idle
    mdu_issue = 1; mdu_issue_addr = 5; chk_addr1 = 5;
    step();
    mdu_issue = 0; mdu_valid = 1; mdu_addr = 5; mdu_data = 32'hCAFE;
    step();
    idle();
    repeat (2) step();
    // FIFO head competing with continuous WB traffic
    mdu_issue = 1; mdu_issue_addr = 6; chk_addr2 = 6;
    step();
    mdu_issue = 0; mdu_valid = 1; mdu_addr = 6; mdu_data = 32'hBEEF;
    wb_valid = 1; wb_addr = 9; wb_data = 32'h99;
    step();
    mdu_valid = 0;
    repeat (7) step();
    idle();
    repeat (3) step();
    // fill the FIFO, then overflow it
    for (int i = 10; i < 13; i++) begin
      mdu_issue = 1; mdu_issue_addr = 5'(i);
      step();
    end
    idle();
    wb_valid = 1; wb_addr = 9; wb_data = 32'h55; chk_addr1 = 10; chk_addr2 = 11;
    for (int i = 10; i < 13; i++) begin
      mdu_valid = 1; mdu_addr = 5'(i); mdu_data = 32'hA000 + 32'(i);
      step();
    end
    mdu_valid = 0;
    // write to $0 does not occupy the port
    wb_addr = 0;
    step();
    idle();
    repeat (3) step();
    // reset with buffered results and pending bits
    reset = 1;
    step();
    reset = 0;
    mdu_issue = 1; mdu_issue_addr = 5; chk_addr1 = 5; chk_addr2 = 7;
    step();
    mdu_issue_addr = 7;
    step();
    mdu_issue = 0; wb_valid = 1; wb_addr = 9; wb_data = 32'h77;
    mdu_valid = 1; mdu_addr = 5; mdu_data = 32'h5;
    step();
    mdu_addr = 7; mdu_data = 32'h7;
    step();
    mdu_valid = 0; reset = 1;
    step();
    reset = 0;
    idle();
    repeat (2) step();
    // randomized phases, each starting from reset
    for (int r = 0; r < 6; r++) begin
      idle();
      reset = 1;
      step();
      reset = 0;
      for (int n = 0; n < 300; n++) rand_cycle();
    end
    idle();
    repeat (3) step();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
